// File: rtl/feature_frame_buffer.sv
// Ping-pong frame buffer that groups a no-backpressure feature stream into FRAME_LEN-word frames
// and replays each frame over valid/ready. Optional output saturation via FEAT_CLAMP_EN.
module feature_frame_buffer #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FRAME_LEN = 39,
   parameter int unsigned CLAMP_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_first,
   output logic              m_last,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   if (FRAME_LEN < 2 || FRAME_LEN > 64 || CLAMP_W < 2 || CLAMP_W > DATA_W) begin : g_bad_param
      $error("feature_frame_buffer: illegal FRAME_LEN or CLAMP_W");
   end

`ifdef FEAT_CLAMP_EN
   localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'((64'd1 << (CLAMP_W - 1)) - 64'd1);
   localparam logic [DATA_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

   // Output shaping applied as a word enters the output slot.
   function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] w);
`ifdef FEAT_CLAMP_EN
      if ($signed(w) > $signed(SAT_MAX)) begin
         return SAT_MAX;
      end
      if ($signed(w) < $signed(SAT_MIN)) begin
         return SAT_MIN;
      end
      return w;
`else
      return w;
`endif
   endfunction

   typedef enum logic {FILL, DISCARD} wr_state_t;

   wr_state_t         state;
   wr_state_t         state_next;
   logic [DATA_W-1:0] mem [2][FRAME_LEN];
   logic [1:0]        full;
   logic [1:0]        full_next;
   logic              wr_bank;
   logic              rd_bank;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              load;
   logic              bank_free;
   logic              frame_start;
   logic              accept;
   logic              wr_en;
   logic              drop_frame;

   assign load        = full[rd_bank] && (!m_valid || m_ready);
   assign bank_free   = load && (rd_idx == LAST_IDX);
   assign frame_start = valid_in && (wr_idx == '0);
   // A bank released by the reader at this same edge counts as empty.
   assign accept      = !full[wr_bank] || (bank_free && (rd_bank == wr_bank));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      drop_frame = 1'b0;
      if (frame_start) begin
         if (accept) begin
            state_next = FILL;
            wr_en      = 1'b1;
         end else begin
            state_next = DISCARD;
            drop_frame = 1'b1;
         end
      end else if (valid_in) begin
         if (state == FILL) begin
            wr_en = 1'b1;
         end else if (wr_idx == LAST_IDX) begin
            state_next = FILL;
         end
      end
   end

   always_comb begin
      full_next = full;
      if (bank_free) begin
         full_next[rd_bank] = 1'b0;
      end
      if (wr_en && (wr_idx == LAST_IDX)) begin
         full_next[wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_idx] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_idx   <= '0;
         rd_idx   <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         m_first  <= 1'b0;
         m_last   <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         full <= full_next;
         if (valid_in) begin
            wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
         end
         if (wr_en && (wr_idx == LAST_IDX)) begin
            wr_bank <= ~wr_bank;
         end
         if (drop_frame) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
         if (load) begin
            m_valid <= 1'b1;
            m_data  <= shape(mem[rd_bank][rd_idx]);
            m_first <= (rd_idx == '0);
            m_last  <= (rd_idx == LAST_IDX);
            if (rd_idx == LAST_IDX) begin
               rd_idx  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_idx <= rd_idx + IDX_W'(1);
            end
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_feature_frame_buffer.sv
// Bench for feature_frame_buffer: directed table and sequences on a FRAME_LEN=4 instance checked
// against a frame-queue reference model, plus a FRAME_LEN=39 streaming run.
module tb_feature_frame_buffer;

   localparam int L  = 4;
   localparam int LB = 39;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] din;
   logic        vin;
   logic        rdy;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_first;
   logic        m_last;
   logic        overflow;
   logic [7:0]  drop_cnt;

   logic [31:0] din_b;
   logic        vin_b;
   logic        rdy_b;
   logic [31:0] m_data_b;
   logic        m_valid_b;
   logic        m_first_b;
   logic        m_last_b;
   logic        overflow_b;
   logic [7:0]  drop_cnt_b;

   always #5 clk = ~clk;

   feature_frame_buffer #(.DATA_W(32), .FRAME_LEN(L), .CLAMP_W(16)) dut (
      .clk(clk), .rst(rst), .data_in(din), .valid_in(vin),
      .m_data(m_data), .m_valid(m_valid), .m_ready(rdy), .m_first(m_first), .m_last(m_last),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   feature_frame_buffer #(.DATA_W(32), .FRAME_LEN(LB), .CLAMP_W(16)) dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .valid_in(vin_b),
      .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(rdy_b), .m_first(m_first_b),
      .m_last(m_last_b), .overflow(overflow_b), .drop_cnt(drop_cnt_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_val(input logic [31:0] x);
`ifdef FEAT_CLAMP_EN
      if ($signed(x) > 32767) return 32'h0000_7FFF;
      if ($signed(x) < -32768) return 32'hFFFF_8000;
`endif
      return x;
   endfunction

   // Reference model: stored words in arrival order, frame occupancy count, one output slot.
   logic [31:0] st_q[$];
   logic [31:0] got_q[$];
   int          avail;
   int          banks_used;
   int          in_pos;
   int          out_pos;
   bit          in_acc;
   bit          s_valid;
   bit          s_first;
   bit          s_last;
   logic [31:0] s_data;
   bit          s_ovf;
   int          s_drops;
   int          b_cnt;

   function automatic void model_reset();
      st_q.delete();
      avail = 0; banks_used = 0; in_pos = 0; out_pos = 0; in_acc = 1'b0;
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_data = '0;
      s_ovf = 1'b0; s_drops = 0;
   endfunction

   function automatic void model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      if ((!s_valid || rdy) && avail > 0) begin
         s_data  = exp_val(st_q.pop_front());
         s_first = (out_pos == 0);
         s_last  = (out_pos == L - 1);
         s_valid = 1'b1;
         avail--;
         if (out_pos == L - 1) begin
            out_pos = 0;
            banks_used--;
         end else begin
            out_pos++;
         end
      end else if (s_valid && rdy) begin
         s_valid = 1'b0;
      end
      if (vin) begin
         if (in_pos == 0) begin
            in_acc = (banks_used < 2);
            if (in_acc) begin
               banks_used++;
            end else begin
               s_ovf = 1'b1;
               if (s_drops < 255) s_drops++;
            end
         end
         if (in_acc) begin
            st_q.push_back(din);
            if (in_pos == L - 1) avail += L;
         end
         in_pos = (in_pos + 1) % L;
      end
   endfunction

   task automatic step();
      if (m_valid && rdy) got_q.push_back(m_data);
      @(posedge clk);
      model_edge();
      #1;
      check("model_valid", 64'(m_valid), 64'(s_valid));
      if (s_valid) begin
         check("model_data", 64'(m_data), 64'(s_data));
         check("model_first", 64'(m_first), 64'(s_first));
         check("model_last", 64'(m_last), 64'(s_last));
      end
      check("model_overflow", 64'(overflow), 64'(s_ovf));
      check("model_drop_cnt", 64'(drop_cnt), 64'(s_drops));
      if (m_valid_b) begin
         check("long_data", 64'(m_data_b), 64'(exp_val(32'(b_cnt))));
         check("long_first", 64'(m_first_b), 64'((b_cnt % LB) == 0));
         check("long_last", 64'(m_last_b), 64'((b_cnt % LB) == LB - 1));
         b_cnt++;
      end
   endtask

   task automatic cyc(input bit v, input logic [31:0] d, input bit r);
      vin = v; din = d; rdy = r;
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check({tag, "_m_first"}, 64'(m_first), 64'd0);
      check({tag, "_m_last"}, 64'(m_last), 64'd0);
      check({tag, "_m_data"}, 64'(m_data), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
      check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
   endtask

   typedef struct {
      bit          v;
      logic [31:0] d;
      bit          ev;
      logic [31:0] ed;
      bit          ef;
      bit          el;
   } vec_t;

   vec_t        tbl[9];
   logic [31:0] clamp_in[4];
   logic [31:0] clamp_exp[4];

   initial begin
      tbl[0] = '{1'b1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0};

      clamp_in[0] = 32'h0001_2345; clamp_in[1] = 32'hFFFE_0000;
      clamp_in[2] = 32'h0000_0010; clamp_in[3] = 32'hFFFF_FFF0;
`ifdef FEAT_CLAMP_EN
      clamp_exp[0] = 32'h0000_7FFF; clamp_exp[1] = 32'hFFFF_8000;
`else
      clamp_exp[0] = 32'h0001_2345; clamp_exp[1] = 32'hFFFE_0000;
`endif
      clamp_exp[2] = 32'h0000_0010; clamp_exp[3] = 32'hFFFF_FFF0;

      rst = 1'b1; vin = 1'b0; din = '0; rdy = 1'b0;
      vin_b = 1'b0; din_b = '0; rdy_b = 1'b1;
      b_cnt = 0;
      model_reset();
      step();
      step();
      rst = 1'b0;
      check_reset_outputs("reset");

      // Single frame through the table
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].v, tbl[i].d, 1'b1);
         check($sformatf("tbl%0d_valid", i), 64'(m_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            check($sformatf("tbl%0d_data", i), 64'(m_data), 64'(tbl[i].ed));
            check($sformatf("tbl%0d_first", i), 64'(m_first), 64'(tbl[i].ef));
            check($sformatf("tbl%0d_last", i), 64'(m_last), 64'(tbl[i].el));
         end
      end

      // Three frames while stalled: third is dropped, first two replay in order
      got_q.delete();
      for (int i = 0; i < 12; i++) cyc(1'b1, 32'(16 + i), 1'b0);
      cyc(1'b0, '0, 1'b0);
      check("stall_overflow", 64'(overflow), 64'd1);
      check("stall_drop_cnt", 64'(drop_cnt), 64'd1);
      for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);
      check("stall_count", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check($sformatf("stall_word%0d", i), 64'(got_q[i]), 64'(16 + i));
      check("stall_valid_end", 64'(m_valid), 64'd0);

      // Ready toggling every cycle
      got_q.delete();
      for (int i = 0; i < 20; i++) cyc(i < 4, 32'(40 + i), (i % 2) == 0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
      check("toggle_count", 64'(got_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("toggle_word%0d", i), 64'(got_q[i]), 64'(40 + i));

      // Reset in mid-frame discards the partial frame
      cyc(1'b1, 32'd200, 1'b1);
      cyc(1'b1, 32'd201, 1'b1);
      rst = 1'b1;
      cyc(1'b0, '0, 1'b1);
      rst = 1'b0;
      check_reset_outputs("midrst");
      got_q.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(300 + i), 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
      check("midrst_count", 64'(got_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("midrst_word%0d", i), 64'(got_q[i]), 64'(300 + i));

      // Saturation boundary words
      got_q.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1, clamp_in[i], 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
      check("clamp_count", 64'(got_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("clamp_word%0d", i), 64'(got_q[i]), 64'(clamp_exp[i]));

      // Randomized traffic with varying consumer pressure
      for (int blk = 0; blk < 6; blk++) begin
         int rdy_pct;
         rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
         for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 99) < rdy_pct);
            rst = 1'b0;
         end
      end
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);

      // Long frames, back-to-back words, consumer always ready
      b_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         vin_b = 1'b1; din_b = 32'(i);
         cyc(1'b0, '0, 1'b1);
      end
      vin_b = 1'b0;
      for (int i = 0; i < 60; i++) cyc(1'b0, '0, 1'b1);
      check("long_words_out", 64'(b_cnt), 64'd195);
      check("long_valid_end", 64'(m_valid_b), 64'd0);
      check("long_overflow", 64'(overflow_b), 64'd0);
      check("long_drop_cnt", 64'(drop_cnt_b), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
